// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the RAM scan reader.
//   RAM_ADDR_W / RAM_DATA_W : default RAM address and word widths
//   scan_state_e            : scan FSM state type
package ram_pkg;

  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/addr_wrap_counter.sv
// addr_wrap_counter: loadable address counter that wraps modulo 2^ADDR_W.
//   clk, reset : clock and synchronous active-high reset
//   load       : load load_addr (wins over inc)
//   load_addr  : value to load
//   inc        : advance by one, last address wraps to zero
//   count      : current address
//   at_last    : count is the all-ones (terminal) address
module addr_wrap_counter
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              at_last
);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_d;

  // Next count: load has priority, increment relies on natural overflow to wrap.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_addr;
    end else if (inc) begin
      count_d = count_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {ADDR_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_last = &count_q;

endmodule

// File: rtl/ram_scan_reader.sv
// ram_scan_reader: walks a synchronous-read RAM address by address and
// presents each word to a consumer with a valid/ready handshake.
//   clk, reset  : clock and synchronous active-high reset
//   start       : begin a scan at start_addr (only honoured when idle)
//   start_addr  : first address of the scan
//   one_pass    : captured with start; 1 = stop after the last address
//   stop        : abort the scan immediately, discarding any pending word
//   ram_addr    : registered RAM read address
//   ram_data    : RAM read data, one edge after the address edge
//   data_out    : word presented to the consumer
//   addr_out    : address of data_out
//   valid       : data_out/addr_out hold a word
//   ready       : consumer accepts the word when valid && ready
//   busy        : scan in progress
//   done        : one-cycle pulse when a one-pass scan completes
// The block only reads; it has no RAM write-enable.
module ram_scan_reader
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              one_pass,
  input  logic              stop,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              done
);

  scan_state_e       state_q, state_d;
  // WAIT spans two edges: the RAM samples ram_addr on the first, and the
  // read word is captured on the second.
  logic              wait_phase_q, wait_phase_d;
  logic              one_pass_q, one_pass_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cnt_load;
  logic              cnt_inc;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_last;

  addr_wrap_counter #(
    .ADDR_W(ADDR_W)
  ) u_cur_addr (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_addr(start_addr),
    .inc      (cnt_inc),
    .count    (cur_addr),
    .at_last  (cur_last)
  );

  // Scan FSM next-state and output-register logic; stop overrides everything.
  always_comb begin
    state_d      = state_q;
    wait_phase_d = wait_phase_q;
    one_pass_d   = one_pass_q;
    ram_addr_d   = ram_addr_q;
    data_out_d   = data_out_q;
    addr_out_d   = addr_out_q;
    valid_d      = valid_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;

    if (stop) begin
      state_d      = ST_IDLE;
      wait_phase_d = 1'b0;
      valid_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_ISSUE;
            cnt_load   = 1'b1;
            one_pass_d = one_pass;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          ram_addr_d   = cur_addr;
          wait_phase_d = 1'b0;
          state_d      = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_phase_q) begin
            data_out_d   = ram_data;
            addr_out_d   = cur_addr;
            valid_d      = 1'b1;
            wait_phase_d = 1'b0;
            state_d      = ST_HOLD;
          end else begin
            wait_phase_d = 1'b1;
          end
        end
        ST_HOLD: begin
          if (ready) begin
            valid_d = 1'b0;
            if (one_pass_q && cur_last) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              cnt_inc = 1'b1;
              state_d = ST_ISSUE;
            end
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          wait_phase_d = 1'b0;
          valid_d      = 1'b0;
        end
      endcase
    end

    // busy is registered from the next state so it lines up with state_q.
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_phase_q <= 1'b0;
      one_pass_q   <= 1'b0;
      ram_addr_q   <= {ADDR_W{1'b0}};
      data_out_q   <= {DATA_W{1'b0}};
      addr_out_q   <= {ADDR_W{1'b0}};
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_phase_q <= wait_phase_d;
      one_pass_q   <= one_pass_d;
      ram_addr_q   <= ram_addr_d;
      data_out_q   <= data_out_d;
      addr_out_q   <= addr_out_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign data_out = data_out_q;
  assign addr_out = addr_out_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// tb_ram_scan_reader: self-checking bench for ram_scan_reader with a
// behavioural synchronous-read RAM and an address-sequence reference model.
module tb_ram_scan_reader;

  localparam int AW = 5;
  localparam int DW = 4;
  localparam int NWORDS = 32;
  localparam int LAT = 4; // negedges from the start/handshake edge's preceding negedge to valid

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          one_pass;
  logic          stop;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] data_out;
  logic [AW-1:0] addr_out;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [0:NWORDS-1];

  int checks;
  int failures;

  ram_scan_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_addr(start_addr),
    .one_pass  (one_pass),
    .stop      (stop),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .data_out  (data_out),
    .addr_out  (addr_out),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears one edge after the address is sampled.
  always @(posedge clk) ram_data <= mem[ram_addr];

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (ram_addr !== 5'd0) begin failures++; $display("FAIL reset_ram_addr got=%0d exp=0", ram_addr); end
    checks++; if (data_out !== 4'd0) begin failures++; $display("FAIL reset_data_out got=%0d exp=0", data_out); end
    checks++; if (addr_out !== 5'd0) begin failures++; $display("FAIL reset_addr_out got=%0d exp=0", addr_out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One pass from address 0 with mem[a] = a mod 16 and ready held high.
  task automatic test_full_pass;
    int lat;
    int dcount;
    for (int a = 0; a < NWORDS; a++) mem[a] = 4'(a % 16);
    dcount = 0;
    start_addr = 5'd0; one_pass = 1'b1; ready = 1'b1; start = 1'b1;
    for (int w = 0; w < NWORDS; w++) begin
      lat = 0;
      do begin
        @(negedge clk); start = 1'b0; lat++;
        if (done === 1'b1) dcount++;
      end while (valid !== 1'b1 && lat < 20);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL full_latency word=%0d got=%0d exp=%0d", w, lat, LAT); end
      checks++; if (addr_out !== 5'(w)) begin failures++; $display("FAIL full_addr got=%0d exp=%0d", addr_out, w); end
      checks++; if (data_out !== 4'(w % 16)) begin failures++; $display("FAIL full_data addr=%0d got=%0d exp=%0d", w, data_out, w % 16); end
    end
    @(negedge clk);
    checks++; if (dcount !== 0) begin failures++; $display("FAIL full_early_done got=%0d exp=0", dcount); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_done got=%0b exp=1", done); end
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL full_idle busy=%0b valid=%0b exp=0,0", busy, valid); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_done_pulse got=%0b exp=0", done); end
    ready = 1'b0;
  endtask

  // Continuous scan from 30 wraps through 31 to 0.
  task automatic test_wrap;
    int lat;
    int exp_a;
    start_addr = 5'd30; one_pass = 1'b0; ready = 1'b1; start = 1'b1;
    exp_a = 30;
    for (int w = 0; w < 4; w++) begin
      lat = 0;
      do begin @(negedge clk); start = 1'b0; lat++; end while (valid !== 1'b1 && lat < 20);
      checks++; if (addr_out !== 5'(exp_a)) begin failures++; $display("FAIL wrap_addr got=%0d exp=%0d", addr_out, exp_a); end
      checks++; if (data_out !== mem[exp_a]) begin failures++; $display("FAIL wrap_data got=%0d exp=%0d", data_out, mem[exp_a]); end
      exp_a = (exp_a + 1) % NWORDS;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; ready = 1'b0;
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL wrap_stop busy=%0b valid=%0b exp=0,0", busy, valid); end
  endtask

  // Consumer stalls 5 cycles on address 4; the word must hold, then 5 follows.
  task automatic test_backpressure;
    int lat;
    start_addr = 5'd4; one_pass = 1'b0; ready = 1'b0; start = 1'b1;
    lat = 0;
    do begin @(negedge clk); start = 1'b0; lat++; end while (valid !== 1'b1 && lat < 20);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL bp_first_latency got=%0d exp=%0d", lat, LAT); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (valid !== 1'b1 || addr_out !== 5'd4 || data_out !== mem[4]) begin
        failures++; $display("FAIL bp_hold cyc=%0d valid=%0b addr=%0d data=%0d exp=1,4,%0d", c, valid, addr_out, data_out, mem[4]);
      end
    end
    ready = 1'b1;
    lat = 0;
    do begin @(negedge clk); ready = 1'b0; lat++; end while (valid !== 1'b1 && lat < 20);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL bp_next_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (addr_out !== 5'd5 || data_out !== mem[5]) begin failures++; $display("FAIL bp_next_word addr=%0d data=%0d exp=5,%0d", addr_out, data_out, mem[5]); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // stop during WAIT: straight back to idle, nothing is ever presented.
  task automatic test_stop_wait;
    int vseen;
    start_addr = 5'd10; one_pass = 1'b1; ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;   // after start edge: ISSUE
    @(negedge clk);                 // after issue edge: WAIT
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL stop_wait busy=%0b valid=%0b done=%0b exp=0,0,0", busy, valid, done);
    end
    vseen = 0;
    repeat (5) begin @(negedge clk); if (valid === 1'b1 || busy === 1'b1) vseen++; end
    checks++; if (vseen !== 0) begin failures++; $display("FAIL stop_wait_quiet got=%0d exp=0", vseen); end
    ready = 1'b0;
  endtask

  // stop with ready in HOLD on the last address of a one-pass scan: no done.
  task automatic test_stop_hold;
    int lat;
    start_addr = 5'd31; one_pass = 1'b1; ready = 1'b0; start = 1'b1;
    lat = 0;
    do begin @(negedge clk); start = 1'b0; lat++; end while (valid !== 1'b1 && lat < 20);
    checks++; if (addr_out !== 5'd31) begin failures++; $display("FAIL stop_hold_addr got=%0d exp=31", addr_out); end
    ready = 1'b1; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; ready = 1'b0;
    checks++; if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL stop_hold busy=%0b valid=%0b done=%0b exp=0,0,0", busy, valid, done);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL stop_hold_late_done got=%0b exp=0", done); end
  endtask

  // start while busy is ignored; reset (with start and stop) in HOLD clears all.
  task automatic test_busy_start_reset;
    int lat;
    start_addr = 5'd7; one_pass = 1'b0; ready = 1'b0; start = 1'b1;
    lat = 0;
    do begin @(negedge clk); start = 1'b0; lat++; end while (valid !== 1'b1 && lat < 20);
    checks++; if (addr_out !== 5'd7) begin failures++; $display("FAIL busy_first_addr got=%0d exp=7", addr_out); end
    start = 1'b1; start_addr = 5'd20;
    repeat (2) @(negedge clk);
    start = 1'b0; ready = 1'b1;
    lat = 0;
    do begin @(negedge clk); ready = 1'b0; lat++; end while (valid !== 1'b1 && lat < 20);
    checks++; if (addr_out !== 5'd8 || data_out !== mem[8]) begin failures++; $display("FAIL busy_start_ignored addr=%0d data=%0d exp=8,%0d", addr_out, data_out, mem[8]); end
    reset = 1'b1; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    checks++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ram_addr !== 5'd0 || data_out !== 4'd0 || addr_out !== 5'd0) begin
      failures++; $display("FAIL hold_reset valid=%0b busy=%0b done=%0b ram_addr=%0d data=%0d addr=%0d exp=all 0", valid, busy, done, ram_addr, data_out, addr_out);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_stays_idle got=%0b exp=0", busy); end
  endtask

  // Random RAM contents, start addresses, modes and consumer stalls.
  task automatic test_random;
    int lat;
    int op;
    int sa;
    int nw;
    int exp_a;
    int hold;
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < NWORDS; a++) mem[a] = 4'($urandom);
      op = it % 2;
      sa = (op == 1) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 31));
      nw = (op == 1) ? (NWORDS - sa) : int'($urandom_range(3, 6));
      start_addr = 5'(sa); one_pass = op[0]; ready = 1'b1; start = 1'b1;
      exp_a = sa;
      for (int w = 0; w < nw; w++) begin
        lat = 0;
        do begin @(negedge clk); start = 1'b0; lat++; end while (valid !== 1'b1 && lat < 20);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL rnd_latency it=%0d got=%0d exp=%0d", it, lat, LAT); end
        checks++; if (addr_out !== 5'(exp_a) || data_out !== mem[exp_a] || ram_addr !== 5'(exp_a)) begin
          failures++; $display("FAIL rnd_word it=%0d addr=%0d data=%0d ram_addr=%0d exp=%0d,%0d", it, addr_out, data_out, ram_addr, exp_a, mem[exp_a]);
        end
        hold = 0;
        while ($urandom_range(0, 2) == 0 && hold < 4) begin
          ready = 1'b0;
          @(negedge clk);
          hold++;
          checks++; if (valid !== 1'b1 || addr_out !== 5'(exp_a) || data_out !== mem[exp_a]) begin
            failures++; $display("FAIL rnd_hold it=%0d valid=%0b addr=%0d data=%0d exp=1,%0d,%0d", it, valid, addr_out, data_out, exp_a, mem[exp_a]);
          end
        end
        ready = 1'b1;
        exp_a = (exp_a + 1) % NWORDS;
      end
      if (op == 1) begin
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rnd_done it=%0d done=%0b busy=%0b exp=1,0", it, done, busy); end
      end else begin
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
          failures++; $display("FAIL rnd_stop it=%0d done=%0b busy=%0b valid=%0b exp=0,0,0", it, done, busy, valid);
        end
      end
      ready = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; start_addr = 5'd0; one_pass = 1'b0; stop = 1'b0; ready = 1'b0;
    for (int a = 0; a < NWORDS; a++) mem[a] = 4'd0;
    @(negedge clk);
    test_reset();
    test_full_pass();
    test_wrap();
    test_backpressure();
    test_stop_wait();
    test_stop_hold();
    test_busy_start_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_scan_reader.md
RAM_SCAN_READER -- requirements
Module: ram_scan_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning RAM address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 4, meaning RAM word width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a scan at start_addr; sampled only in IDLE.
REQ-006 SHALL have port start_addr  input  ADDR_W  first address of the scan.
REQ-007 SHALL have port one_pass  input  1  sampled with start: 1 = stop after the word at the last address; 0 = wrap continuously.
REQ-008 SHALL have port stop  input  1  abort the scan.
REQ-009 SHALL have port ram_addr  output  ADDR_W  registered address to the RAM address port.
REQ-010 SHALL have port ram_data  input  DATA_W  RAM read data; registered in the RAM, one-edge latency after the address edge.
REQ-011 SHALL have port data_out  output  DATA_W  word presented to the consumer.
REQ-012 SHALL have port addr_out  output  ADDR_W  address of data_out.
REQ-013 SHALL have port valid  output  1  data_out/addr_out hold a word.
REQ-014 SHALL have port ready  input  1  consumer accepts the word when valid && ready at a rising edge.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse when a one_pass scan completes.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, HOLD.
REQ-018 SHALL move IDLE->ISSUE on start: load cur_addr=start_addr and latch one_pass.
REQ-019 SHALL, in ISSUE, drive ram_addr<=cur_addr and move to WAIT (the RAM samples the address at the next edge).
REQ-020 SHALL, in WAIT, register data_out<=ram_data and addr_out<=cur_addr, set valid<=1, and move to HOLD.
REQ-021 SHALL hold data_out, addr_out and valid stable in HOLD until the edge at which ready=1.
REQ-022 SHALL produce first valid 3 rising edges after the edge that samples start; each further word SHALL take 3 edges after the previous handshake edge.
REQ-023 SHALL, on a handshake with one_pass=1 and cur_addr = 2^ADDR_W-1, clear valid, pulse done for one cycle, and enter IDLE.
REQ-024 SHALL otherwise, on a handshake, clear valid, set cur_addr<=cur_addr+1 modulo 2^ADDR_W (31 wraps to 0), and enter ISSUE.
REQ-025 SHALL, when one_pass=1 and start_addr != 0, read from start_addr through 31 only, with no wrap.
REQ-026 SHALL give stop priority over every other input in every state: next edge enters IDLE, valid<=0, done stays 0, and a pending word is discarded.
REQ-027 SHALL, when stop and ready coincide in HOLD, treat the word as discarded.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL never drive a RAM write-enable; the RAM write port is owned by another block.

Reset
REQ-030 SHALL, on an edge with reset=1 in any state including mid-scan, force state=IDLE, ram_addr=0, cur_addr=0, data_out=0, addr_out=0, valid=0, busy=0, done=0.
REQ-031 SHALL give reset priority over stop and start.

Structure
REQ-032 SHALL place ADDR_W/DATA_W defaults and the state enum type in shared package ram_pkg.
REQ-033 SHALL place the wrapping address counter (load, increment, terminal-count flag) in sub-module addr_wrap_counter.

Verification
REQ-034 SHALL cover: RAM preloaded mem[a]=a[3:0]; start, start_addr=0, one_pass=1, ready=1 -> 32 words, addr_out 0..31, data_out 0..15 twice, done pulses once after word 31.
REQ-035 SHALL cover: start_addr=30, one_pass=0, ready=1 -> addr_out sequence 30, 31, 0, 1.
REQ-036 SHALL cover: ready=0 for 5 cycles during valid on address 4 -> data_out=4, addr_out=4 held; next word is address 5.
REQ-037 SHALL cover: stop asserted in WAIT and, separately, in HOLD with ready=1 -> next edge IDLE, valid=0, done=0, no handshake counted.
REQ-038 SHALL cover: reset asserted in HOLD -> all outputs 0 after one edge; start asserted while busy ignored.
REQ-039 SHALL cover: start -> first valid exactly 3 edges after the start edge, with addr_out=start_addr.
